// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - ID-side bundle between the pipeline and the forwarding/hazard unit
interface fwd_hazard_unit_if #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2
);
    localparam int SELW = $clog2(FWD_STAGES + 1);

    logic [31:0]             instr_ID;
    logic                    id_valid;
    logic                    id_regwen;
    logic                    id_is_load;
    logic [NUM_SRC-1:0]      id_src_used;
    logic                    stall_in;
    logic                    flush_in;
    logic [NUM_SRC*SELW-1:0] fwd_sel;
    logic                    stall_id;
    logic                    bubble_ex;

    modport master (
        output instr_ID, id_valid, id_regwen, id_is_load, id_src_used, stall_in, flush_in,
        input  fwd_sel, stall_id, bubble_ex
    );

    modport slave (
        input  instr_ID, id_valid, id_regwen, id_is_load, id_src_used, stall_in, flush_in,
        output fwd_sel, stall_id, bubble_ex
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - Registered forward selects and load-use stall; FWD_HAZARD_STALL_CNT_EN adds stall_cnt
module fwd_hazard_unit #(
    parameter int NUM_SRC          = 2,
    parameter int FWD_STAGES       = 2,
    parameter int LOAD_READY_STAGE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FWD_HAZARD_STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    fwd_hazard_unit_if.slave bus
);
    localparam int SELW = $clog2(FWD_STAGES + 1);
    localparam int SW   = NUM_SRC * SELW;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } rec_t;

    rec_t          rec_q [FWD_STAGES+1];
    rec_t          rec_d [FWD_STAGES+1];
    rec_t          id_rec;
    logic [SW-1:0] fwd_sel_q;
    logic [SW-1:0] fwd_sel_d;
    logic [SW-1:0] sel_next;
    logic [4:0]    src [NUM_SRC];
    logic          load_use;
    logic          found;
    logic          stall_id;
    logic          bubble_ex;
    logic          unused_instr;

    // Opcode/funct bits play no part in hazard detection.
    assign unused_instr = ^bus.instr_ID;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            case (s)
                0:       src[s] = bus.instr_ID[19:15];
                1:       src[s] = bus.instr_ID[24:20];
                default: src[s] = bus.instr_ID[31:27];
            endcase
        end
    end

    always_comb begin
        id_rec.valid   = 1'b1;
        id_rec.rd      = bus.instr_ID[11:7];
        id_rec.we      = bus.id_regwen && (bus.instr_ID[11:7] != 5'd0);
        id_rec.is_load = bus.id_is_load;
    end

    // Scan from EX outward; the first hit is the youngest writer and masks older ones.
    always_comb begin
        sel_next = '0;
        load_use = 1'b0;
        found    = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            found = 1'b0;
            for (int k = 0; k <= FWD_STAGES; k++) begin
                if (!found && bus.id_src_used[s] && (src[s] != 5'd0) &&
                    rec_q[k].valid && rec_q[k].we && (rec_q[k].rd == src[s])) begin
                    found = 1'b1;
                    if (k < FWD_STAGES) begin
                        sel_next[s*SELW +: SELW] = SELW'(k + 1);
                    end
                    if (rec_q[k].is_load && ((k + 1) < LOAD_READY_STAGE)) begin
                        load_use = 1'b1;
                    end
                end
            end
        end
    end

    assign stall_id  = bus.id_valid && !bus.flush_in && load_use;
    assign bubble_ex = stall_id && !bus.stall_in;

    always_comb begin
        rec_d     = rec_q;
        fwd_sel_d = fwd_sel_q;
        if (!bus.stall_in) begin
            for (int k = FWD_STAGES; k > 0; k--) begin
                rec_d[k] = rec_q[k-1];
            end
            if (bus.id_valid && !stall_id && !bus.flush_in) begin
                rec_d[0] = id_rec;
            end else begin
                rec_d[0] = '0;
            end
            if (stall_id || bus.flush_in) begin
                fwd_sel_d = '0;
            end else begin
                fwd_sel_d = sel_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= FWD_STAGES; k++) begin
                rec_q[k] <= '0;
            end
            fwd_sel_q <= '0;
        end else begin
            for (int k = 0; k <= FWD_STAGES; k++) begin
                rec_q[k] <= rec_d[k];
            end
            fwd_sel_q <= fwd_sel_d;
        end
    end

    assign bus.fwd_sel   = fwd_sel_q;
    assign bus.stall_id  = stall_id;
    assign bus.bubble_ex = bubble_ex;

`ifdef FWD_HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bubble_ex && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule
